// File: rtl/seg7_scan4_pkg.sv
// Shared constants and types for the 4-digit 7-segment scanner and its decoder.
//   SEG_BLANK / SEG_DASH : all-off and dash segment patterns (a=bit0 .. g=bit6)
//   BCD_SEG              : segment patterns for BCD values 0..9
//   SCAN_W / DIGIT_W / SEG_W : widths of the digit index, one BCD digit, the segment bus
package seg7_scan4_pkg;

    localparam int unsigned SCAN_W  = 2;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned NDIGITS = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;

    // Element k holds the pattern for BCD value k (listed 9 down to 0).
    localparam logic [9:0][SEG_W-1:0] BCD_SEG = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Position inside a digit slot: blank guard time, then the digit itself.
    typedef enum logic {
        SLOT_GAP  = 1'b0,
        SLOT_SHOW = 1'b1
    } slot_t;

endpackage

// File: rtl/seg7_scan4_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to 7-segment decoder (active-high segments).
//   bcd   : 4-bit digit
//   seg_c : segment pattern, a=bit0 .. g=bit6; values 10..15 show a dash
module bcd_to_seg7
    import seg7_scan4_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        if (bcd < 4'd10) begin
            seg_c = BCD_SEG[bcd];
        end
    end

endmodule

// File: rtl/seg7_scan4.sv
// seg7_scan4: multiplexed 4-digit 7-segment display scanner.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   EN         : scan enable; low freezes the scan and blanks the display
//   DIGITS     : four BCD digits, [3:0] least significant .. [15:12] most significant
//   LZB        : leading-zero blanking enable (applied live)
//   SCAN_IDX   : registered active digit index for the external 2-to-4 decoder
//   SEG        : registered segments, active high, aligned with SCAN_IDX
//   FRAME      : registered one-cycle pulse after each frame sample of DIGITS
module seg7_scan4
    import seg7_scan4_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GAP_CYC  = 500
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN,
    input  logic [15:0]          DIGITS,
    input  logic                 LZB,
    output logic [SCAN_W-1:0]    SCAN_IDX,
    output logic [SEG_W-1:0]     SEG,
    output logic                 FRAME
);

    localparam int unsigned PCNT_W = $clog2(SCAN_DIV);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);

    logic [PCNT_W-1:0]                 pcnt;
    logic [PCNT_W-1:0]                 pcnt_nx;
    logic [SCAN_W-1:0]                 idx_nx;
    logic [NDIGITS-1:0][DIGIT_W-1:0]   shadow;
    logic [NDIGITS-1:0][DIGIT_W-1:0]   shadow_nx;
    logic [DIGIT_W-1:0]                digit_sel;
    logic [SEG_W-1:0]                  digit_seg;
    logic [SEG_W-1:0]                  seg_nx;
    logic                              load_c;
    logic                              in_gap_c;
    logic                              lz_blank;
    slot_t                             slot_nx;

    // Guard time is measured on the upcoming count so SEG lines up with SCAN_IDX.
    if (GAP_CYC == 0) begin : g_no_gap
        assign in_gap_c = 1'b0;
    end else begin : g_gap
        assign in_gap_c = (32'(pcnt_nx) < GAP_CYC);
    end

    // Decoder sees the digit that will be on display after the next edge.
    bcd_to_seg7 u_dec (
        .bcd   (digit_sel),
        .seg_c (digit_seg)
    );

    // Next-state: prescaler, slot index, frame load, segment selection.
    always_comb begin
        pcnt_nx   = pcnt;
        idx_nx    = SCAN_IDX;
        load_c    = EN && (SCAN_IDX == '0) && (pcnt == '0);
        shadow_nx = shadow;
        lz_blank  = 1'b0;
        seg_nx    = SEG_BLANK;

        if (EN) begin
            if (pcnt == PCNT_LAST) begin
                pcnt_nx = '0;
                idx_nx  = SCAN_W'(SCAN_IDX + 1'b1);
            end else begin
                pcnt_nx = PCNT_W'(pcnt + 1'b1);
            end
        end

        if (load_c) begin
            shadow_nx = DIGITS;
        end

        digit_sel = shadow_nx[idx_nx];

        // A digit is blank when it and every more-significant digit are zero.
        case (idx_nx)
            2'd3:    lz_blank = (shadow_nx[3] == '0);
            2'd2:    lz_blank = (shadow_nx[3] == '0) && (shadow_nx[2] == '0);
            2'd1:    lz_blank = (shadow_nx[3] == '0) && (shadow_nx[2] == '0)
                                && (shadow_nx[1] == '0);
            default: lz_blank = 1'b0;
        endcase

        slot_nx = in_gap_c ? SLOT_GAP : SLOT_SHOW;

        if (EN && (slot_nx == SLOT_SHOW) && !(LZB && lz_blank)) begin
            seg_nx = digit_seg;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcnt     <= '0;
            SCAN_IDX <= '0;
            SEG      <= SEG_BLANK;
            FRAME    <= 1'b0;
            shadow   <= '0;
        end else begin
            pcnt     <= pcnt_nx;
            SCAN_IDX <= idx_nx;
            SEG      <= seg_nx;
            FRAME    <= load_c;
            shadow   <= shadow_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan4.sv
// Scoreboard bench for seg7_scan4 (SCAN_DIV=4, GAP_CYC=1): each driven cycle
// pushes the hand-computed post-edge outputs; a monitor pops and compares.
module tb_seg7_scan4;

    logic        CLK;
    logic        RST_N;
    logic        EN;
    logic [15:0] DIGITS;
    logic        LZB;
    logic [1:0]  SCAN_IDX;
    logic [6:0]  SEG;
    logic        FRAME;

    typedef struct {
        logic [1:0] idx;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_vec    = 0;

    seg7_scan4 #(
        .SCAN_DIV (4),
        .GAP_CYC  (1)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .DIGITS   (DIGITS),
        .LZB      (LZB),
        .SCAN_IDX (SCAN_IDX),
        .SEG      (SEG),
        .FRAME    (FRAME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    // Drive one cycle (from a negedge) and queue the outputs expected after the edge.
    task automatic step(input logic en, input logic [15:0] dig, input logic lzb,
                        input logic [1:0] e_idx, input logic [6:0] e_seg,
                        input logic e_frame);
        exp_t e;
        EN     = en;
        DIGITS = dig;
        LZB    = lzb;
        e.idx   = e_idx;
        e.seg   = e_seg;
        e.frame = e_frame;
        exp_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One full digit slot starting at PCNT=0: three SHOW cycles, then gap of the next slot.
    task automatic slot(input logic [15:0] dig, input logic lzb, input logic [1:0] idx,
                        input logic [6:0] seg, input logic fr);
        logic [1:0] nxt;
        nxt = 2'(idx + 2'd1);
        step(1'b1, dig, lzb, idx, seg, fr);
        step(1'b1, dig, lzb, idx, seg, 1'b0);
        step(1'b1, dig, lzb, idx, seg, 1'b0);
        step(1'b1, dig, lzb, nxt, 7'h00, 1'b0);
    endtask

    // Monitor: compare every queued expectation just after its clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                chk($sformatf("v%0d SCAN_IDX", n_vec), int'(SCAN_IDX), int'(e.idx));
                chk($sformatf("v%0d SEG", n_vec), int'(SEG), int'(e.seg));
                chk($sformatf("v%0d FRAME", n_vec), int'(FRAME), int'(e.frame));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N  = 1'b0;
        EN     = 1'b0;
        DIGITS = 16'h0000;
        LZB    = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("reset SCAN_IDX", int'(SCAN_IDX), 0);
        chk("reset SEG", int'(SEG), 0);
        chk("reset FRAME", int'(FRAME), 0);
        @(negedge CLK);

        // 1. Normal scan of 1234 (digit0=4 .. digit3=1).
        slot(16'h1234, 1'b0, 2'd0, 7'h66, 1'b1);
        slot(16'h1234, 1'b0, 2'd1, 7'h4F, 1'b0);
        slot(16'h1234, 1'b0, 2'd2, 7'h5B, 1'b0);
        slot(16'h1234, 1'b0, 2'd3, 7'h06, 1'b0);

        // 2. DIGITS changes mid-frame; rest of the frame keeps the old sample.
        slot(16'h1234, 1'b0, 2'd0, 7'h66, 1'b1);
        slot(16'h5678, 1'b0, 2'd1, 7'h4F, 1'b0);
        slot(16'h5678, 1'b0, 2'd2, 7'h5B, 1'b0);
        slot(16'h5678, 1'b0, 2'd3, 7'h06, 1'b0);
        slot(16'h5678, 1'b0, 2'd0, 7'h7F, 1'b1);
        slot(16'h5678, 1'b0, 2'd1, 7'h07, 1'b0);
        slot(16'h5678, 1'b0, 2'd2, 7'h7D, 1'b0);
        slot(16'h5678, 1'b0, 2'd3, 7'h6D, 1'b0);

        // 3. Leading-zero blanking.
        slot(16'h0040, 1'b1, 2'd0, 7'h3F, 1'b1);
        slot(16'h0040, 1'b1, 2'd1, 7'h66, 1'b0);
        slot(16'h0040, 1'b1, 2'd2, 7'h00, 1'b0);
        slot(16'h0040, 1'b1, 2'd3, 7'h00, 1'b0);
        slot(16'h0000, 1'b1, 2'd0, 7'h3F, 1'b1);
        slot(16'h0000, 1'b1, 2'd1, 7'h00, 1'b0);
        slot(16'h0000, 1'b1, 2'd2, 7'h00, 1'b0);
        slot(16'h0000, 1'b1, 2'd3, 7'h00, 1'b0);
        slot(16'h0000, 1'b0, 2'd0, 7'h3F, 1'b1);
        slot(16'h0000, 1'b0, 2'd1, 7'h3F, 1'b0);
        slot(16'h0000, 1'b0, 2'd2, 7'h3F, 1'b0);
        slot(16'h0000, 1'b0, 2'd3, 7'h3F, 1'b0);

        // 4. Non-BCD digits show a dash.
        slot(16'hFA09, 1'b0, 2'd0, 7'h6F, 1'b1);
        slot(16'hFA09, 1'b0, 2'd1, 7'h3F, 1'b0);
        slot(16'hFA09, 1'b0, 2'd2, 7'h40, 1'b0);
        slot(16'hFA09, 1'b0, 2'd3, 7'h40, 1'b0);

        // 5. Enable hold at SCAN_IDX=2, PCNT=1.
        slot(16'h1234, 1'b0, 2'd0, 7'h66, 1'b1);
        slot(16'h1234, 1'b0, 2'd1, 7'h4F, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 2'd2, 7'h5B, 1'b0);
        repeat (5) step(1'b0, 16'h1234, 1'b0, 2'd2, 7'h00, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 2'd2, 7'h5B, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 2'd2, 7'h5B, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 2'd3, 7'h00, 1'b0);
        slot(16'h1234, 1'b0, 2'd3, 7'h06, 1'b0);

        // 6. Asynchronous reset during idx3 SHOW.
        slot(16'h1234, 1'b0, 2'd0, 7'h66, 1'b1);
        slot(16'h1234, 1'b0, 2'd1, 7'h4F, 1'b0);
        slot(16'h1234, 1'b0, 2'd2, 7'h5B, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 2'd3, 7'h06, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 2'd3, 7'h06, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async rst SCAN_IDX", int'(SCAN_IDX), 0);
        chk("async rst SEG", int'(SEG), 0);
        chk("async rst FRAME", int'(FRAME), 0);
        @(posedge CLK);
        #1;
        chk("held rst SEG", int'(SEG), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        slot(16'h5678, 1'b0, 2'd0, 7'h7F, 1'b1);
        slot(16'h5678, 1'b0, 2'd1, 7'h07, 1'b0);

        @(posedge CLK);
        #2;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
